// File: rtl/traffic_sensor_counter.sv
// Per-street vehicle counter: synchronises and debounces two raw detectors, counts rising
// edges of the debounced level and publishes saturating counts once per measurement window.
module traffic_sensor_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned WINDOW_CYCLES   = 64,
  parameter int unsigned COUNT_WIDTH     = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   sensor_street_0_i,
  input  logic                   sensor_street_1_i,
  input  logic                   window_enable_i,
  input  logic                   clear_i,
  output logic [COUNT_WIDTH-1:0] traffic_street_0_o,
  output logic [COUNT_WIDTH-1:0] traffic_street_1_o,
  output logic                   overflow_street_0_o,
  output logic                   overflow_street_1_o,
  output logic                   snapshot_valid_o
);

  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TimerW = $clog2(WINDOW_CYCLES);

  localparam logic [DbW-1:0]         DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TimerW-1:0]      TimerLast = TimerW'(WINDOW_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CountMax  = '1;

  logic [1:0] sensor;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] deb_q, deb_d;
  logic [1:0] deb_prev_q;
  logic [1:0] evt;
  logic [1:0] hit_max;

  logic [1:0][DbW-1:0]         db_cnt_q, db_cnt_d;
  logic [1:0][COUNT_WIDTH-1:0] acc_q, acc_d, acc_next;
  logic [1:0][COUNT_WIDTH-1:0] traffic_q, traffic_d;
  logic [1:0]                  sat_q, sat_d, sat_next;
  logic [1:0]                  ovf_q, ovf_d;

  logic [TimerW-1:0] timer_q, timer_d;
  logic              valid_q, valid_d;
  logic              terminal;

  assign sensor = {sensor_street_1_i, sensor_street_0_i};

  // Two-flop synchronisers for the asynchronous detector inputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sensor;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: level flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      deb_q      <= '0;
      deb_prev_q <= '0;
      db_cnt_q   <= '0;
    end else begin
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      db_cnt_q   <= db_cnt_d;
    end
  end

  assign evt = deb_q & ~deb_prev_q;

  // Window timer; the terminal cycle publishes the running totals.
  assign terminal = window_enable_i && (timer_q == TimerLast);

  always_comb begin
    timer_d = timer_q;
    if (clear_i) begin
      timer_d = '0;
    end else if (window_enable_i) begin
      timer_d = terminal ? '0 : timer_q + 1'b1;
    end
  end

  // Saturating accumulate, including any event in the current cycle.
  always_comb begin
    hit_max  = '0;
    acc_next = acc_q;
    sat_next = sat_q;
    for (int i = 0; i < 2; i++) begin
      hit_max[i] = evt[i] && (acc_q[i] == CountMax);
      if (evt[i] && !hit_max[i]) begin
        acc_next[i] = acc_q[i] + 1'b1;
      end
      sat_next[i] = sat_q[i] | hit_max[i];
    end
  end

  // Clear wins over both a terminal cycle and pending events.
  always_comb begin
    acc_d     = acc_next;
    sat_d     = sat_next;
    traffic_d = traffic_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;
    if (clear_i) begin
      acc_d = '0;
      sat_d = '0;
    end else if (terminal) begin
      acc_d     = '0;
      sat_d     = '0;
      traffic_d = acc_next;
      ovf_d     = sat_next;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q   <= '0;
      acc_q     <= '0;
      sat_q     <= '0;
      traffic_q <= '0;
      ovf_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      acc_q     <= acc_d;
      sat_q     <= sat_d;
      traffic_q <= traffic_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
    end
  end

  assign traffic_street_0_o  = traffic_q[0];
  assign traffic_street_1_o  = traffic_q[1];
  assign overflow_street_0_o = ovf_q[0];
  assign overflow_street_1_o = ovf_q[1];
  assign snapshot_valid_o    = valid_q;

endmodule
